// File: rtl/psram_line_buffer.sv
// Ping-pong scanline buffer: PSRAM read words fill one bank while the other
// bank is replayed pixel-by-pixel as RGB888 on the pixel clock.
module psram_line_buffer #(
  parameter int LINE_PIXELS = 768,
  parameter int ADDR_W      = 9,
  parameter bit REPLICATE   = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        line_start,
  input  logic        wr_valid,
  input  logic [31:0] wr_data,
  input  logic        active,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        out_valid,
  output logic        overflow,
  output logic        underrun
);

  localparam int WORDS  = LINE_PIXELS / 2;
  localparam int PTR_W  = ADDR_W + 2;
  localparam int MEM_AW = ADDR_W + 1;

  localparam logic [PTR_W-1:0] WORDS_P = PTR_W'(WORDS);
  localparam logic [PTR_W-1:0] LINE_P  = PTR_W'(LINE_PIXELS);

  logic [31:0]       mem [0:2*WORDS-1];

  logic              wr_bank;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_pix;
  logic [PTR_W-1:0]  rd_limit;

  logic              wr_en;
  logic [MEM_AW-1:0] wr_idx;
  logic [MEM_AW-1:0] rd_idx;
  logic [PTR_W-1:0]  rd_word_addr;
  logic [PTR_W-1:0]  rd_ofs;
  logic              rd_inrange;
  logic              rd_stored;

  logic [31:0]       rd_word;
  logic              s1_active;
  logic              s1_odd;
  logic              s1_inrange;
  logic              s1_stored;

  logic [15:0]       pix;
  logic [23:0]       pix_rgb;

  function automatic logic [PTR_W-1:0] bank_base(input logic bank);
    return bank ? WORDS_P : '0;
  endfunction

  function automatic logic [23:0] expand(input logic [15:0] p);
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    if (REPLICATE) begin
      r = {p[15:11], p[15:13]};
      g = {p[10:5],  p[10:9]};
      b = {p[4:0],   p[4:2]};
    end else begin
      r = {p[15:11], 3'b000};
      g = {p[10:5],  2'b00};
      b = {p[4:0],   3'b000};
    end
    return {r, g, b};
  endfunction

  // A word coincident with line_start lands at address 0 of the bank that
  // becomes the write bank on this edge.
  always_comb begin
    wr_en  = 1'b0;
    wr_idx = '0;
    if (!reset) begin
      if (line_start) begin
        wr_en  = wr_valid;
        wr_idx = MEM_AW'(bank_base(~wr_bank));
      end else if (wr_valid && (wr_ptr < WORDS_P)) begin
        wr_en  = 1'b1;
        wr_idx = MEM_AW'(bank_base(wr_bank) + wr_ptr);
      end
    end
  end

  // Past the end of the line the address is clamped; the data is masked anyway.
  always_comb begin
    rd_word_addr = rd_pix >> 1;
    rd_ofs       = (rd_word_addr < WORDS_P) ? rd_word_addr : (WORDS_P - PTR_W'(1));
    rd_idx       = MEM_AW'(bank_base(~wr_bank) + rd_ofs);
    rd_stored    = (rd_pix < LINE_P);
    rd_inrange   = (rd_word_addr < rd_limit) && rd_stored;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
    rd_word <= mem[rd_idx];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_bank  <= 1'b0;
      wr_ptr   <= '0;
      rd_pix   <= '0;
      rd_limit <= '0;
      overflow <= 1'b0;
    end else begin
      if (line_start) begin
        rd_limit <= wr_ptr;
        wr_bank  <= ~wr_bank;
        wr_ptr   <= wr_valid ? PTR_W'(1) : '0;
      end else if (wr_valid) begin
        if (wr_ptr < WORDS_P) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end else begin
          overflow <= 1'b1;
        end
      end

      if (line_start) begin
        rd_pix <= '0;
      end else if (active && rd_stored) begin
        rd_pix <= rd_pix + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_active  <= 1'b0;
      s1_odd     <= 1'b0;
      s1_inrange <= 1'b0;
      s1_stored  <= 1'b0;
    end else begin
      s1_active  <= active;
      s1_odd     <= rd_pix[0];
      s1_inrange <= rd_inrange;
      s1_stored  <= rd_stored;
    end
  end

  always_comb begin
    pix     = s1_odd ? rd_word[31:16] : rd_word[15:0];
    pix_rgb = expand(pix);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      red       <= '0;
      green     <= '0;
      blue      <= '0;
      out_valid <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      out_valid <= s1_active;
      if (s1_active && s1_inrange) begin
        {red, green, blue} <= pix_rgb;
      end else begin
        {red, green, blue} <= '0;
      end
      if (s1_active && !s1_inrange && s1_stored) begin
        underrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_psram_line_buffer.sv
// Self-checking bench for psram_line_buffer against a line-level reference model.
module tb_psram_line_buffer;

  localparam int LP    = 768;
  localparam int WORDS = LP / 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        line_start = 1'b0;
  logic        wr_valid = 1'b0;
  logic [31:0] wr_data = '0;
  logic        active = 1'b0;
  logic [7:0]  red, green, blue, red0, green0, blue0;
  logic        out_valid, overflow, underrun;
  logic        out_valid0, overflow0, underrun0;

  int checks = 0;
  int failures = 0;

  logic [31:0] mbank [2][WORDS];
  int          mwb, mwp, mlimit;
  bit          movf, mund;
  logic [23:0] cap0, cap1, cap766, cap767, cap0_z, cap1_z;

  always #5 clk = ~clk;

  psram_line_buffer #(.LINE_PIXELS(LP), .ADDR_W(9), .REPLICATE(1'b1)) dut (
    .clk(clk), .reset(reset), .line_start(line_start), .wr_valid(wr_valid),
    .wr_data(wr_data), .active(active), .red(red), .green(green), .blue(blue),
    .out_valid(out_valid), .overflow(overflow), .underrun(underrun));

  psram_line_buffer #(.LINE_PIXELS(LP), .ADDR_W(9), .REPLICATE(1'b0)) dut0 (
    .clk(clk), .reset(reset), .line_start(line_start), .wr_valid(wr_valid),
    .wr_data(wr_data), .active(active), .red(red0), .green(green0), .blue(blue0),
    .out_valid(out_valid0), .overflow(overflow0), .underrun(underrun0));

  function automatic logic [23:0] expand(input int p, input bit rep);
    int r5, g6, b5, r8, g8, b8;
    r5 = (p >> 11) & 31;
    g6 = (p >> 5) & 63;
    b5 = p & 31;
    r8 = r5 * 8 + (rep ? r5 / 4 : 0);
    g8 = g6 * 4 + (rep ? g6 / 16 : 0);
    b8 = b5 * 8 + (rep ? b5 / 4 : 0);
    return 24'(r8 * 65536 + g8 * 256 + b8);
  endfunction

  function automatic logic [23:0] exp_pix(input int p, input bit rep);
    logic [31:0] w;
    int half;
    if (p >= LP || p / 2 >= mlimit) return 24'h0;
    w = mbank[mwb ^ 1][p / 2];
    half = (p % 2 == 1) ? int'(w >> 16) : int'(w & 32'hFFFF);
    return expand(half, rep);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    mwb = 0; mwp = 0; mlimit = 0; movf = 0; mund = 0;
  endtask

  task automatic model_write(input bit ls, input bit wv, input logic [31:0] d);
    if (ls) begin
      mlimit = mwp;
      mwb = mwb ^ 1;
      mwp = 0;
      if (wv) begin
        mbank[mwb][0] = d;
        mwp = 1;
      end
    end else if (wv) begin
      if (mwp < WORDS) begin
        mbank[mwb][mwp] = d;
        mwp++;
      end else begin
        movf = 1;
      end
    end
  endtask

  task automatic do_cycle(input bit ls, input bit wv, input logic [31:0] d, input bit act);
    line_start = ls;
    wr_valid   = wv;
    wr_data    = d;
    active     = act;
    step();
    model_write(ls, wv, d);
  endtask

  task automatic apply_reset();
    line_start = 0; wr_valid = 0; active = 0;
    reset = 1;
    step();
    reset = 0;
    model_reset();
  endtask

  // Plays n active cycles from the start of a line and checks every output pixel.
  task automatic play_line(input int n, input bit rand_wr);
    for (int c = 0; c <= n + 1; c++) begin
      bit          wv;
      logic [31:0] d;
      logic [23:0] e1, e0;
      int          q;
      wv = rand_wr && ($urandom_range(0, 3) == 0);
      d  = $urandom;
      if (c < n && c < LP && c / 2 >= mlimit) mund = 1;
      do_cycle(0, wv, d, c < n);
      if (c >= 1) begin
        q = c - 1;
        e1 = (q < n) ? exp_pix((q < LP) ? q : LP, 1'b1) : 24'h0;
        e0 = (q < n) ? exp_pix((q < LP) ? q : LP, 1'b0) : 24'h0;
        checks++;
        if (out_valid !== (q < n)) begin
          failures++;
          $display("FAIL out_valid pix%0d: got %b want %b", q, out_valid, q < n);
        end
        checks++;
        if ({red, green, blue} !== e1) begin
          failures++;
          $display("FAIL rgb_rep1 pix%0d: got %h want %h", q, {red, green, blue}, e1);
        end
        checks++;
        if ({red0, green0, blue0} !== e0) begin
          failures++;
          $display("FAIL rgb_rep0 pix%0d: got %h want %h", q, {red0, green0, blue0}, e0);
        end
        if (q == 0)   begin cap0 = {red, green, blue}; cap0_z = {red0, green0, blue0}; end
        if (q == 1)   begin cap1 = {red, green, blue}; cap1_z = {red0, green0, blue0}; end
        if (q == 766) cap766 = {red, green, blue};
        if (q == 767) cap767 = {red, green, blue};
      end
    end
    active = 0; wr_valid = 0;
    checks++;
    if (underrun !== mund) begin
      failures++;
      $display("FAIL underrun_line: got %b want %b", underrun, mund);
    end
    checks++;
    if (overflow !== movf) begin
      failures++;
      $display("FAIL overflow_line: got %b want %b", overflow, movf);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({red, green, blue, out_valid, overflow, underrun} !== 27'h0) begin
      failures++;
      $display("FAIL reset_outputs: got %h/%b/%b/%b want 0", {red, green, blue}, out_valid, overflow, underrun);
    end
    play_line(LP, 1'b1);
  endtask

  task automatic test_fill();
    apply_reset();
    for (int i = 0; i < WORDS; i++) do_cycle(0, 1, (i == 0) ? 32'hF800_001F : $urandom, 0);
    do_cycle(1, 0, 0, 0);
    play_line(LP, 1'b1);
    checks++;
    if (cap0 !== 24'h0000FF) begin
      failures++; $display("FAIL fill_pix0: got %h want 0000ff", cap0);
    end
    checks++;
    if (cap1 !== 24'hFF0000) begin
      failures++; $display("FAIL fill_pix1: got %h want ff0000", cap1);
    end
    checks++;
    if (underrun !== 1'b0) begin
      failures++; $display("FAIL fill_underrun: got %b want 0", underrun);
    end
  endtask

  task automatic test_short_fill();
    apply_reset();
    for (int i = 0; i < 10; i++) do_cycle(0, 1, $urandom, 0);
    do_cycle(1, 0, 0, 0);
    play_line(LP, 1'b1);
    checks++;
    if (underrun !== 1'b1) begin
      failures++; $display("FAIL short_underrun: got %b want 1", underrun);
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int i = 0; i < WORDS + 1; i++) begin
      do_cycle(0, 1, i, 0);
      if (i == WORDS - 1) begin
        checks++;
        if (overflow !== 1'b0) begin
          failures++; $display("FAIL ovf_early: got %b want 0", overflow);
        end
      end
    end
    checks++;
    if (overflow !== 1'b1) begin
      failures++; $display("FAIL ovf_set: got %b want 1", overflow);
    end
    do_cycle(1, 0, 0, 0);
    play_line(LP, 1'b0);
    checks++;
    if (cap766 !== expand(WORDS - 1, 1'b1)) begin
      failures++; $display("FAIL ovf_pix766: got %h want %h", cap766, expand(WORDS - 1, 1'b1));
    end
    checks++;
    if (cap767 !== expand(0, 1'b1)) begin
      failures++; $display("FAIL ovf_pix767: got %h want %h", cap767, expand(0, 1'b1));
    end
  endtask

  task automatic test_coincident();
    apply_reset();
    for (int i = 0; i < WORDS; i++) do_cycle(0, 1, $urandom, 0);
    do_cycle(1, 1, 32'h07E0_07E0, 0);
    play_line(LP, 1'b0);
    do_cycle(1, 0, 0, 0);
    play_line(LP, 1'b0);
    checks++;
    if (cap0 !== 24'h00FF00) begin
      failures++; $display("FAIL coinc_pix0: got %h want 00ff00", cap0);
    end
    checks++;
    if (cap1 !== 24'h00FF00) begin
      failures++; $display("FAIL coinc_pix1: got %h want 00ff00", cap1);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 0; i < 20; i++) do_cycle(0, 1, $urandom, 0);
    do_cycle(1, 0, 0, 0);
    for (int i = 0; i < 100; i++) do_cycle(0, 1, $urandom, 1);
    checks++;
    if (underrun !== 1'b1 || out_valid !== 1'b1) begin
      failures++; $display("FAIL mid_pre: got und=%b vld=%b want 1/1", underrun, out_valid);
    end
    reset = 1;
    do_cycle(0, 0, 0, 1);
    reset = 0;
    model_reset();
    checks++;
    if ({red, green, blue, out_valid, overflow, underrun} !== 27'h0) begin
      failures++;
      $display("FAIL mid_reset: got %h/%b/%b/%b want 0", {red, green, blue}, out_valid, overflow, underrun);
    end
    do_cycle(0, 0, 0, 0);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL mid_pipe_flush: got %b want 0", out_valid);
    end
    do_cycle(1, 0, 0, 0);
    play_line(LP, 1'b0);
  endtask

  task automatic test_replicate();
    apply_reset();
    for (int i = 0; i < WORDS; i++) do_cycle(0, 1, 32'hFFFF_FFFF, 0);
    do_cycle(1, 0, 0, 0);
    play_line(LP, 1'b0);
    checks++;
    if (cap0_z !== 24'hF8FCF8 || cap1_z !== 24'hF8FCF8) begin
      failures++; $display("FAIL rep0_white: got %h %h want f8fcf8", cap0_z, cap1_z);
    end
    checks++;
    if (cap0 !== 24'hFFFFFF || cap1 !== 24'hFFFFFF) begin
      failures++; $display("FAIL rep1_white: got %h %h want ffffff", cap0, cap1);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int l = 0; l < 8; l++) begin
      int nfill;
      nfill = $urandom_range(0, WORDS + 16);
      for (int i = 0; i < nfill; i++) do_cycle(0, 1, $urandom, 0);
      do_cycle(1, $urandom_range(0, 1) == 1, $urandom, 0);
      play_line($urandom_range(200, LP), 1'b1);
    end
  endtask

  initial begin
    model_reset();
    repeat (2) step();
    test_reset();
    test_fill();
    test_short_fill();
    test_overflow();
    test_coincident();
    test_reset_mid();
    test_replicate();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
